// File: rtl/mem_load_unit.sv
// -----------------------------------------------------------------------------
// mem_load_unit
//
// Memory-stage load unit. A load issued from IDLE sends one word-aligned read
// request, freezes the upstream pipeline and waits for dm_ready. The returned
// word is then byte/half/word extracted and registered as a one-cycle
// writeback. A non-load is passed straight through to the writeback registers
// in one cycle. If no data arrives within TIMEOUT wait cycles, the load
// completes with no writeback. The sticky load_err flag records timeouts and
// illegal load types.
//
// Ports
//   clk, rst         : single clock, synchronous active-high reset
//   is_load_mem      : load type (000 none, 001 LW, 010 LH, 011 LB, 100 LHU,
//                      101 LBU, 110 FLW, 111 illegal)
//   alu_out_mem      : byte address for a load, result value otherwise
//   rd_addr_mem      : destination register
//   wb_en_mem        : integer writeback enable
//   float_wb_en_mem  : float writeback enable
//   dm_ready         : read data valid this cycle
//   dm_rdata         : read word
//   dm_req, dm_addr  : read request and word-aligned read address
//   stall            : freeze the upstream pipeline
//   wb_data, rd_addr_wb, wb_en_wb, float_wb_en_wb : registered writeback
//   load_err         : sticky error flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_load_unit #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  is_load_mem,
    input  logic [31:0] alu_out_mem,
    input  logic [4:0]  rd_addr_mem,
    input  logic        wb_en_mem,
    input  logic        float_wb_en_mem,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_addr_wb,
    output logic        wb_en_wb,
    output logic        float_wb_en_wb,
    output logic        load_err
);

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LW   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LB   = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_LBU  = 3'b101;
    localparam logic [2:0] LD_FLW  = 3'b110;
    localparam logic [2:0] LD_ILL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Shift the addressed byte down to bit 0, then extend. Because the shift
    // zero-fills, a halfword at offset 3 naturally sees byte 3 with a zero
    // upper byte, and a misaligned word returns only the upper bytes.
    function automatic logic [31:0] extract_load(input logic [2:0]  ltype,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (ltype)
            LD_LW, LD_FLW: extract_load = sh;
            LD_LH:         extract_load = {{16{sh[15]}}, sh[15:0]};
            LD_LHU:        extract_load = {16'h0000, sh[15:0]};
            LD_LB:         extract_load = {{24{sh[7]}}, sh[7:0]};
            LD_LBU:        extract_load = {24'h000000, sh[7:0]};
            default:       extract_load = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  type_q, type_d;
    logic [4:0]  rd_q, rd_d;
    logic        wben_q, wben_d;
    logic        fwben_q, fwben_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_addr_wb_q, rd_addr_wb_d;
    logic        wb_en_wb_q, wb_en_wb_d;
    logic        fwb_en_wb_q, fwb_en_wb_d;
    logic        err_q, err_d;

    logic        dm_req_s;
    logic [31:0] dm_addr_s;
    logic        stall_s;
    logic        is_load_s;
    logic        timeout_s;

    assign is_load_s = (is_load_mem != LD_NONE) && (is_load_mem != LD_ILL);
    // The current wait cycle is the TIMEOUT-th one without data.
    assign timeout_s = (TIMEOUT != 8'd0) && (cnt_q == (TIMEOUT - 8'd1));

    // Next-state, request/stall and writeback selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        off_d        = off_q;
        type_d       = type_q;
        rd_d         = rd_q;
        wben_d       = wben_q;
        fwben_d      = fwben_q;
        err_d        = err_q;
        // Writeback registers are only non-zero for the one cycle that
        // follows a pass-through or a completed load.
        wb_data_d    = 32'h0000_0000;
        rd_addr_wb_d = 5'd0;
        wb_en_wb_d   = 1'b0;
        fwb_en_wb_d  = 1'b0;
        dm_req_s     = 1'b0;
        dm_addr_s    = 32'h0000_0000;
        stall_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_load_s) begin
                    dm_req_s  = 1'b1;
                    dm_addr_s = {alu_out_mem[31:2], 2'b00};
                    stall_s   = 1'b1;
                    addr_d    = alu_out_mem[31:2];
                    off_d     = alu_out_mem[1:0];
                    type_d    = is_load_mem;
                    rd_d      = rd_addr_mem;
                    wben_d    = wb_en_mem;
                    fwben_d   = float_wb_en_mem;
                    cnt_d     = 8'd0;
                    state_d   = S_WAIT;
                end else if (is_load_mem == LD_ILL) begin
                    wb_data_d    = alu_out_mem;
                    rd_addr_wb_d = rd_addr_mem;
                    err_d        = 1'b1;
                end else begin
                    wb_data_d    = alu_out_mem;
                    rd_addr_wb_d = rd_addr_mem;
                    wb_en_wb_d   = wb_en_mem;
                    fwb_en_wb_d  = float_wb_en_mem;
                end
            end
            S_WAIT: begin
                dm_req_s  = 1'b1;
                dm_addr_s = {addr_q, 2'b00};
                stall_s   = 1'b1;
                // Data arriving on the timeout cycle still completes the load.
                if (dm_ready) begin
                    wb_data_d    = extract_load(type_q, off_q, dm_rdata);
                    rd_addr_wb_d = rd_q;
                    wb_en_wb_d   = wben_q;
                    fwb_en_wb_d  = fwben_q;
                    cnt_d        = 8'd0;
                    state_d      = S_DONE;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and writeback registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= 30'd0;
            off_q        <= 2'd0;
            type_q       <= LD_NONE;
            rd_q         <= 5'd0;
            wben_q       <= 1'b0;
            fwben_q      <= 1'b0;
            wb_data_q    <= 32'h0000_0000;
            rd_addr_wb_q <= 5'd0;
            wb_en_wb_q   <= 1'b0;
            fwb_en_wb_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            type_q       <= type_d;
            rd_q         <= rd_d;
            wben_q       <= wben_d;
            fwben_q      <= fwben_d;
            wb_data_q    <= wb_data_d;
            rd_addr_wb_q <= rd_addr_wb_d;
            wb_en_wb_q   <= wb_en_wb_d;
            fwb_en_wb_q  <= fwb_en_wb_d;
            err_q        <= err_d;
        end
    end

    // The request and stall must already be valid in the issuing cycle, so
    // they are decoded from state; rst masks them so a reset cycle never
    // requests memory or freezes the pipeline.
    assign dm_req         = dm_req_s & ~rst;
    assign dm_addr        = rst ? 32'h0000_0000 : dm_addr_s;
    assign stall          = stall_s & ~rst;
    assign wb_data        = wb_data_q;
    assign rd_addr_wb     = rd_addr_wb_q;
    assign wb_en_wb       = wb_en_wb_q;
    assign float_wb_en_wb = fwb_en_wb_q;
    assign load_err       = err_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_load_unit
//
// Directed bench for mem_load_unit (TIMEOUT overridden to 4). Inputs are
// driven on the falling edge; combinational outputs are checked 1 ns later
// and registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_load_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  is_load_mem;
    logic [31:0] alu_out_mem;
    logic [4:0]  rd_addr_mem;
    logic        wb_en_mem;
    logic        float_wb_en_mem;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic        float_wb_en_wb;
    logic        load_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_load_unit #(.TIMEOUT(8'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .is_load_mem    (is_load_mem),
        .alu_out_mem    (alu_out_mem),
        .rd_addr_mem    (rd_addr_mem),
        .wb_en_mem      (wb_en_mem),
        .float_wb_en_mem(float_wb_en_mem),
        .dm_ready       (dm_ready),
        .dm_rdata       (dm_rdata),
        .dm_req         (dm_req),
        .dm_addr        (dm_addr),
        .stall          (stall),
        .wb_data        (wb_data),
        .rd_addr_wb     (rd_addr_wb),
        .wb_en_wb       (wb_en_wb),
        .float_wb_en_wb (float_wb_en_wb),
        .load_err       (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] typ, input logic [31:0] a, input logic [4:0] rd,
                         input logic we, input logic fwe);
        is_load_mem     = typ;
        alu_out_mem     = a;
        rd_addr_mem     = rd;
        wb_en_mem       = we;
        float_wb_en_mem = fwe;
    endtask

    // Issue a load from IDLE, wait nwait cycles, return data, stop in DONE.
    // Upstream inputs are scrambled during WAIT; only latched values count.
    task automatic run_load(input string tag, input logic [2:0] typ, input logic [31:0] a,
                            input logic [4:0] rd, input logic we, input logic fwe,
                            input logic [31:0] rdata, input int nwait);
        logic [31:0] word_addr;
        word_addr = {a[31:2], 2'b00};
        @(negedge clk);
        drive(typ, a, rd, we, fwe);
        dm_ready = 1'b0;
        #1;
        chk({tag, ".req"},   32'(dm_req), 32'd1);
        chk({tag, ".addr"},  dm_addr, word_addr);
        chk({tag, ".stall"}, 32'(stall), 32'd1);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            drive(3'b011, ~a, ~rd, ~we, ~fwe);
            #1;
            chk({tag, ".wait_addr"}, dm_addr, word_addr);
        end
        @(negedge clk);
        drive(3'b000, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0);
        dm_ready = 1'b1;
        dm_rdata = rdata;
        #1;
        chk({tag, ".wait_stall"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, ".done_stall"}, 32'(stall), 32'd0);
        chk({tag, ".done_req"},   32'(dm_req), 32'd0);
    endtask

    // Leave DONE and confirm the writeback lasted exactly one cycle.
    task automatic finish_done(input string tag);
        @(negedge clk);
        dm_ready = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".wb_en_cleared"}, 32'(wb_en_wb | float_wb_en_wb), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b001, 32'h0000_1000, 5'd1, 1'b1, 1'b0);
        dm_ready = 1'b0;
        dm_rdata = 32'h0;

        // Reset: outputs cleared, no request/stall even with a load presented.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.rd",      32'(rd_addr_wb), 32'd0);
        chk("rst.wb_en",   32'(wb_en_wb), 32'd0);
        chk("rst.fwb_en",  32'(float_wb_en_wb), 32'd0);
        chk("rst.err",     32'(load_err), 32'd0);
        chk("rst.req",     32'(dm_req), 32'd0);
        chk("rst.stall",   32'(stall), 32'd0);

        // Non-load pass-through; dm_ready in IDLE is ignored.
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 32'h1234_5678, 5'd5, 1'b1, 1'b0);
        dm_ready = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        #1;
        chk("pass.stall", 32'(stall), 32'd0);
        chk("pass.req",   32'(dm_req), 32'd0);
        @(posedge clk);
        #1;
        chk("pass.wb_data", wb_data, 32'h1234_5678);
        chk("pass.rd",      32'(rd_addr_wb), 32'd5);
        chk("pass.wb_en",   32'(wb_en_wb), 32'd1);
        chk("pass.stall2",  32'(stall), 32'd0);

        // LB at offset 3, data one cycle after the request.
        run_load("lb", 3'b011, 32'h0000_1003, 5'd7, 1'b1, 1'b0, 32'h80FF_0000, 0);
        chk("lb.wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb.rd",      32'(rd_addr_wb), 32'd7);
        chk("lb.wb_en",   32'(wb_en_wb), 32'd1);
        finish_done("lb");

        // LHU / LH at offset 2.
        run_load("lhu", 3'b100, 32'h0000_2002, 5'd8, 1'b1, 1'b0, 32'hBEEF_1234, 0);
        chk("lhu.wb_data", wb_data, 32'h0000_BEEF);
        finish_done("lhu");
        run_load("lh", 3'b010, 32'h0000_2002, 5'd8, 1'b1, 1'b0, 32'hBEEF_1234, 0);
        chk("lh.wb_data", wb_data, 32'hFFFF_BEEF);
        finish_done("lh");

        // LH at offset 3: only byte 3, upper byte zero so no sign extension.
        run_load("lh3", 3'b010, 32'h0000_2003, 5'd9, 1'b1, 1'b0, 32'h8000_0000, 0);
        chk("lh3.wb_data", wb_data, 32'h0000_0080);
        finish_done("lh3");

        // Misaligned LW after a 2-cycle memory delay.
        run_load("lw1", 3'b001, 32'h0000_4001, 5'd10, 1'b1, 1'b0, 32'hAABB_CCDD, 2);
        chk("lw1.wb_data", wb_data, 32'h00AA_BBCC);
        chk("lw1.rd",      32'(rd_addr_wb), 32'd10);
        finish_done("lw1");

        // LBU at offset 2.
        run_load("lbu", 3'b101, 32'h0000_4002, 5'd11, 1'b1, 1'b0, 32'hAABB_CCDD, 1);
        chk("lbu.wb_data", wb_data, 32'h0000_00BB);
        finish_done("lbu");

        // FLW writes the float register file only.
        run_load("flw", 3'b110, 32'h0000_3000, 5'd12, 1'b0, 1'b1, 32'h3F80_0000, 0);
        chk("flw.wb_data", wb_data, 32'h3F80_0000);
        chk("flw.fwb_en",  32'(float_wb_en_wb), 32'd1);
        chk("flw.wb_en",   32'(wb_en_wb), 32'd0);
        finish_done("flw");

        // Illegal type: error, pass-through with enables forced low.
        @(negedge clk);
        drive(3'b111, 32'hCAFE_F00D, 5'd3, 1'b1, 1'b1);
        #1;
        chk("ill.stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        chk("ill.wb_data", wb_data, 32'hCAFE_F00D);
        chk("ill.rd",      32'(rd_addr_wb), 32'd3);
        chk("ill.wb_en",   32'(wb_en_wb | float_wb_en_wb), 32'd0);
        chk("ill.err",     32'(load_err), 32'd1);
        @(negedge clk);
        drive(3'b000, 32'h0000_0001, 5'd2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("ill.sticky", 32'(load_err), 32'd1);
        chk("ill.next_en", 32'(wb_en_wb), 32'd1);

        // Reset pulse clears the sticky flag.
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("clr.err", 32'(load_err), 32'd0);

        // Timeout: four WAIT cycles without data.
        @(negedge clk);
        rst = 1'b0;
        drive(3'b001, 32'h0000_5000, 5'd9, 1'b1, 1'b0);
        dm_ready = 1'b0;
        #1;
        chk("to.req", 32'(dm_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
            #1;
            chk("to.wait_stall", 32'(stall), 32'd1);
            chk("to.wait_err",   32'(load_err), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("to.err",     32'(load_err), 32'd1);
        chk("to.wb_en",   32'(wb_en_wb | float_wb_en_wb), 32'd0);
        chk("to.wb_data", wb_data, 32'h0);
        chk("to.stall",   32'(stall), 32'd0);
        // DONE ignores a new load; IDLE accepts it on the following cycle.
        @(negedge clk);
        drive(3'b001, 32'h0000_6000, 5'd4, 1'b1, 1'b0);
        #1;
        chk("to.done_req", 32'(dm_req), 32'd0);
        @(posedge clk);
        #1;
        chk("to.idle_req",  32'(dm_req), 32'd1);
        chk("to.idle_addr", dm_addr, 32'h0000_6000);

        // Reset during WAIT aborts the load; late dm_ready writes nothing.
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw.req_in_rst",   32'(dm_req), 32'd0);
        chk("rw.stall_in_rst", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        chk("rw.err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        dm_ready = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rw.stall", 32'(stall), 32'd0);
        chk("rw.req",   32'(dm_req), 32'd0);
        @(posedge clk);
        #1;
        chk("rw.wb_data", wb_data, 32'h0);
        chk("rw.rd",      32'(rd_addr_wb), 32'd0);
        chk("rw.wb_en",   32'(wb_en_wb | float_wb_en_wb), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
